fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/seq_pkg.sv | 23 ++
 rtl/pc_next_calc.sv | 33 +++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the fetch sequencer
package seq_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int RET_W   = 16;

    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_BR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Major opcode field of an instruction word
    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1:INSTR_W-3];
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-pc and range-fault calculation
module pc_next_calc
    import seq_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               br_cond,
    output logic [PC_W-1:0]    next_pc,
    output logic               fault
);

    logic          taken;
    logic [4:0]    offset;
    logic [PC_W:0] sum;

    // One extra bit of headroom: both overflow past 1023 and underflow below 0
    // land with the top bit set, so it doubles as the out-of-range flag.
    always_comb begin
        taken  = (opcode_of(instr) == OP_BR) && br_cond;
        offset = instr[4:0];
        sum    = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};
        if (taken) begin
            if (instr[5]) begin
                sum = {1'b0, pc} + {{(PC_W-4){1'b0}}, offset};
            end else begin
                sum = {1'b0, pc} - {{(PC_W-4){1'b0}}, offset};
            end
        end
        next_pc = sum[PC_W-1:0];
        fault   = sum[PC_W] | (taken && (offset == 5'd0));
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/issue sequencer with pc range checking
module fetch_sequencer
    import seq_pkg::*;
(
    input  logic               CLK,
    input  logic               init_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               br_cond,
    input  logic               ex_done,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [RET_W-1:0]   retire_cnt
);

    seq_state_t      state;
    seq_state_t      state_nx;

    logic            do_start;
    logic            do_latch;
    logic            do_retire;
    logic            do_advance;
    logic            do_fault;
    logic            is_halt;

    logic [PC_W-1:0] calc_pc;
    logic            calc_fault;

    pc_next_calc u_pc_next_calc (
        .pc      (pc),
        .instr   (instr),
        .br_cond (br_cond),
        .next_pc (calc_pc),
        .fault   (calc_fault)
    );

    assign imem_addr = pc;
    assign is_halt   = (opcode_of(instr) == OP_HALT);

    // State register
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nx   = state;
        do_start   = 1'b0;
        do_latch   = 1'b0;
        do_retire  = 1'b0;
        do_advance = 1'b0;
        do_fault   = 1'b0;
        imem_req   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    do_start = 1'b1;
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) begin
                    do_latch = 1'b1;
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy = 1'b1;
                // HALT always leaves on its first EXEC cycle, so no first-cycle
                // qualifier is needed here.
                if (is_halt) begin
                    do_retire = 1'b1;
                    state_nx  = ST_DONE;
                end else if (ex_done) begin
                    // The datapath has completed the instruction, so it retires
                    // even when the resulting pc would be out of range.
                    do_retire = 1'b1;
                    if (calc_fault) begin
                        do_fault = 1'b1;
                        state_nx = ST_DONE;
                    end else begin
                        do_advance = 1'b1;
                        state_nx   = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    do_start = 1'b1;
                    state_nx = ST_FETCH;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Program counter, instruction latch, issue pulse, fault flag and retire counter
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            instr_valid <= do_latch;
            if (do_start) begin
                pc         <= start_addr;
                fault      <= 1'b0;
                retire_cnt <= '0;
            end
            if (do_latch) begin
                instr <= imem_data;
            end
            if (do_advance) begin
                pc <= calc_pc;
            end
            if (do_fault) begin
                fault <= 1'b1;
            end
            if (do_retire && (retire_cnt != {RET_W{1'b1}})) begin
                retire_cnt <= retire_cnt + {{(RET_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic       CLK = 1'b0;
    logic       init_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] start_addr = '0;
    logic       imem_ack = 1'b0;
    logic [8:0] imem_data = '0;
    logic       br_cond = 1'b0;
    logic       ex_done = 1'b0;

    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] retire_cnt;

    fetch_sequencer dut (
        .CLK         (CLK),
        .init_n      (init_n),
        .start       (start),
        .start_addr  (start_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .br_cond     (br_cond),
        .ex_done     (ex_done),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .retire_cnt  (retire_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_DONE  = 3;

    int         m_ph = P_IDLE;
    int         m_pc = 0;
    int         m_retire = 0;
    logic [8:0] m_instr = '0;
    bit         m_fault = 1'b0;
    bit         m_iv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Target address by plain integer arithmetic; -1 marks an out-of-range result
    function automatic int calc_next(input int p, input logic [8:0] ins, input logic brc);
        int off;
        int r;
        off = int'(ins[4:0]);
        r = p + 1;
        if (ins[8:6] == 3'b111 && brc) begin
            if (off == 0) return -1;
            r = ins[5] ? p + off : p - off;
        end
        if (r < 0 || r > 1023) return -1;
        return r;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Reference behaviour of the sequencer, one step per rising edge
    always @(posedge CLK) begin
        if (!init_n) begin
            m_ph     <= P_IDLE;
            m_pc     <= 0;
            m_instr  <= '0;
            m_retire <= 0;
            m_fault  <= 1'b0;
            m_iv     <= 1'b0;
        end else begin
            m_iv <= (m_ph == P_FETCH) && imem_ack;
            case (m_ph)
                P_IDLE, P_DONE: begin
                    if (start) begin
                        m_pc     <= int'(start_addr);
                        m_fault  <= 1'b0;
                        m_retire <= 0;
                        m_ph     <= P_FETCH;
                    end
                end
                P_FETCH: begin
                    if (imem_ack) begin
                        m_instr <= imem_data;
                        m_ph    <= P_EXEC;
                    end
                end
                P_EXEC: begin
                    if (m_instr[8:6] == 3'b110) begin
                        m_retire <= sat_inc(m_retire);
                        m_ph     <= P_DONE;
                    end else if (ex_done) begin
                        m_retire <= sat_inc(m_retire);
                        if (calc_next(m_pc, m_instr, br_cond) < 0) begin
                            m_fault <= 1'b1;
                            m_ph    <= P_DONE;
                        end else begin
                            m_pc <= calc_next(m_pc, m_instr, br_cond);
                            m_ph <= P_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the reference
    always @(negedge CLK) begin
        if (chk_en) begin
            check("imem_req",    imem_req,    (m_ph == P_FETCH));
            check("imem_addr",   imem_addr,   m_pc);
            check("pc",          pc,          m_pc);
            check("instr",       instr,       m_instr);
            check("instr_valid", instr_valid, m_iv);
            check("busy",        busy,        (m_ph == P_FETCH || m_ph == P_EXEC));
            check("done",        done,        (m_ph == P_DONE));
            check("fault",       fault,       m_fault);
            check("retire_cnt",  retire_cnt,  m_retire);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
    endtask

    task automatic start_prog(input logic [9:0] addr);
        start = 1'b1;
        start_addr = addr;
        tick();
        start = 1'b0;
    endtask

    // Serve one fetch and one execute, with ignored-input noise while waiting
    task automatic run_instr(input logic [8:0] data, input int ack_dly, input int done_dly, input logic brc);
        repeat (ack_dly) begin
            start = 1'b1;
            start_addr = 10'd5;
            tick();
        end
        start = 1'b0;
        imem_ack = 1'b1;
        imem_data = data;
        tick();
        imem_ack = 1'b0;
        repeat (done_dly) begin
            imem_ack = 1'b1;
            imem_data = ~data;
            br_cond = ~brc;
            start = 1'b1;
            tick();
        end
        imem_ack = 1'b0;
        start = 1'b0;
        ex_done = 1'b1;
        br_cond = brc;
        tick();
        ex_done = 1'b0;
        br_cond = 1'b0;
    endtask

    initial begin
        init_n = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", imem_req, 0);
        init_n = 1'b1;
        tick();

        // Basic sequential fetch/execute from address 10
        start_prog(10'd10);
        check("start_lat_req", imem_req, 1);
        run_instr(9'b000000001, 2, 0, 1'b0);
        check("seq_pc", pc, 11);
        check("seq_retire", retire_cnt, 1);
        check("exdone_lat_req", imem_req, 1);
        run_instr(9'b000000111, 0, 2, 1'b1);
        check("seq2_pc", pc, 12);
        run_instr(9'b111000011, 1, 1, 1'b1);
        check("bwd_pc", pc, 9);
        check("bwd_retire", retire_cnt, 3);

        // Forward branch taken / not taken from pc 20
        do_reset();
        start_prog(10'd20);
        run_instr(9'b111100101, 0, 1, 1'b1);
        check("br_taken_pc", pc, 25);
        do_reset();
        start_prog(10'd20);
        run_instr(9'b111100101, 0, 0, 1'b0);
        check("br_not_taken_pc", pc, 21);

        // Backward branch below zero
        do_reset();
        start_prog(10'd3);
        run_instr(9'b111000101, 0, 0, 1'b1);
        check("under_fault", fault, 1);
        check("under_done", done, 1);
        check("under_busy", busy, 0);
        check("under_pc", pc, 3);

        // Sequential step past the top of the address space
        start_prog(10'd1023);
        check("restart_fault_clr", fault, 0);
        run_instr(9'b000000101, 1, 0, 1'b0);
        check("over_fault", fault, 1);
        check("over_pc", pc, 1023);
        start_prog(10'd0);
        check("start_clr_fault", fault, 0);
        check("start_clr_pc", pc, 0);

        // Taken branch with zero offset
        run_instr(9'b111100000, 0, 0, 1'b1);
        check("zero_off_fault", fault, 1);
        check("zero_off_pc", pc, 0);

        // HALT at pc 7 with ex_done held low
        start_prog(10'd7);
        imem_ack = 1'b1;
        imem_data = 9'b110000000;
        tick();
        imem_ack = 1'b0;
        check("halt_iv", instr_valid, 1);
        check("halt_not_yet_done", done, 0);
        tick();
        check("halt_done", done, 1);
        check("halt_pc", pc, 7);
        check("halt_retire", retire_cnt, 1);

        // Untaken zero-offset branch is just sequential
        start_prog(10'd40);
        run_instr(9'b111100000, 0, 0, 1'b0);
        check("zero_off_nt_pc", pc, 41);

        // Reset during FETCH, then a late ack
        do_reset();
        start_prog(10'd10);
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        imem_ack = 1'b1;
        imem_data = 9'h1ff;
        tick();
        imem_ack = 1'b0;
        check("rstf_req", imem_req, 0);
        check("rstf_pc", pc, 0);
        check("rstf_instr", instr, 0);
        check("rstf_busy", busy, 0);

        // Reset during EXEC overrides ex_done
        start_prog(10'd30);
        imem_ack = 1'b1;
        imem_data = 9'b000000011;
        tick();
        imem_ack = 1'b0;
        init_n = 1'b0;
        ex_done = 1'b1;
        tick();
        init_n = 1'b1;
        ex_done = 1'b0;
        check("rste_pc", pc, 0);
        check("rste_retire", retire_cnt, 0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
